// File: rtl/flag_branch_unit_pkg.sv
// Shared definitions for the flag/branch unit: condition codes, flag bit positions
// and FSM state encoding.
package flag_branch_unit_pkg;

    localparam logic [2:0] COND_NEQ    = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GTE    = 3'b100;
    localparam logic [2:0] COND_LTE    = 3'b101;
    localparam logic [2:0] COND_OVFL   = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_V = 0;

    localparam int unsigned CntW = 3;

    typedef enum logic [1:0] {
        StIdle,
        StRedirect,
        StSquash
    } state_e;

endpackage

// File: rtl/flag_branch_unit_if.sv
// Adder-side and branch-side signals of the flag/branch unit, plus its registered outputs.
interface flag_branch_unit_if #(
    parameter int unsigned DW = 16
);
    logic          alu_valid;
    logic [DW-1:0] alu_out;
    logic          zr;
    logic          neg;
    logic          ov;
    logic [2:0]    flag_we;
    logic          br_valid;
    logic [2:0]    br_cond;
    logic [DW-1:0] br_target;

    logic [2:0]    flags_q;
    logic [DW-1:0] result_q;
    logic          result_valid;
    logic          br_taken;
    logic [DW-1:0] br_pc;
    logic          squash;

    modport master (
        output alu_valid, alu_out, zr, neg, ov, flag_we, br_valid, br_cond, br_target,
        input  flags_q, result_q, result_valid, br_taken, br_pc, squash
    );

    modport slave (
        input  alu_valid, alu_out, zr, neg, ov, flag_we, br_valid, br_cond, br_target,
        output flags_q, result_q, result_valid, br_taken, br_pc, squash
    );
endinterface

// File: rtl/flag_branch_unit_branch_cond_eval.sv
// Combinational branch condition resolution from {Z,N,V} flags and a condition code.
module branch_cond_eval
    import flag_branch_unit_pkg::*;
(
    input  logic [2:0] flags_i,
    input  logic [2:0] cond_i,
    output logic       taken_o
);
    logic z, n, v;

    assign z = flags_i[FLG_Z];
    assign n = flags_i[FLG_N];
    assign v = flags_i[FLG_V];

    always_comb begin
        taken_o = 1'b0;
        unique case (cond_i)
            COND_NEQ:    taken_o = !z;
            COND_EQ:     taken_o = z;
            COND_GT:     taken_o = !z && !n;
            COND_LT:     taken_o = n;
            COND_GTE:    taken_o = z || !n;
            COND_LTE:    taken_o = z || n;
            COND_OVFL:   taken_o = v;
            COND_UNCOND: taken_o = 1'b1;
            default:     taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/flag_branch_unit.sv
// Execute-stage flag register, result pipeline register and branch redirect/squash FSM
// downstream of the saturating adder.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter int unsigned DW         = 16,
    parameter int unsigned SQUASH_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               flush_i,
    flag_branch_unit_if.slave  bus
);
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      flags_q, flags_d, flag_in, flag_wr;
    logic [DW-1:0]   result_q, br_pc_q;
    logic            result_valid_q, br_taken_q, squash_q;
    logic            accept, alu_acc, cond_taken;

    assign accept  = (state_q != StSquash);
    assign alu_acc = bus.alu_valid && accept;

    always_comb begin
        flag_in        = '0;
        flag_in[FLG_Z] = bus.zr;
        flag_in[FLG_N] = bus.neg;
        flag_in[FLG_V] = bus.ov;
    end

    // Next flags double as the bypass: an ALU op in the same cycle is older than the branch.
    assign flag_wr = (bus.flag_we & flag_in) | (~bus.flag_we & flags_q);
    assign flags_d = alu_acc ? flag_wr : flags_q;

    branch_cond_eval u_cond_eval (
        .flags_i (flags_d),
        .cond_i  (bus.br_cond),
        .taken_o (cond_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            flags_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            br_taken_q     <= 1'b0;
            br_pc_q        <= '0;
            squash_q       <= 1'b0;
        end else if (flush_i) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            result_valid_q <= 1'b0;
            br_taken_q     <= 1'b0;
            squash_q       <= 1'b0;
        end else if (!stall_i) begin
            flags_q <= flags_d;
            if (accept) begin
                result_q       <= bus.alu_out;
                result_valid_q <= bus.alu_valid;
            end else begin
                result_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.br_valid && cond_taken) begin
                        br_taken_q <= 1'b1;
                        br_pc_q    <= bus.br_target;
                        state_q    <= StRedirect;
                    end else begin
                        br_taken_q <= 1'b0;
                    end
                end
                StRedirect: begin
                    br_taken_q <= 1'b0;
                    squash_q   <= 1'b1;
                    cnt_q      <= CntW'(SQUASH_CYC - 1);
                    state_q    <= StSquash;
                end
                StSquash: begin
                    // Counter is preloaded with SQUASH_CYC-1, so exit happens on the zero cycle.
                    if (cnt_q == '0) begin
                        squash_q <= 1'b0;
                        state_q  <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.flags_q      = flags_q;
    assign bus.result_q     = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.br_taken     = br_taken_q;
    assign bus.br_pc        = br_pc_q;
    assign bus.squash       = squash_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: a cycle model compared every cycle plus literal pins.
module tb_flag_branch_unit;
    localparam int unsigned DW = 16;
    localparam int          SQ = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    flag_branch_unit_if #(.DW(DW)) bus ();

    flag_branch_unit #(.DW(DW), .SQUASH_CYC(SQ)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall_i (stall),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Model state: visible outputs plus redirect-pending bit and remaining squash cycles.
    logic [2:0]    m_flags, n_flags;
    logic [DW-1:0] m_res, n_res, m_pc, n_pc;
    bit            m_rv, n_rv, m_tk, n_tk, m_redir, n_redir;
    int            m_left, n_left;

    function automatic bit cond_ok(logic [2:0] f, logic [2:0] c);
        bit z, n, v;
        z = f[2];
        n = f[1];
        v = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return z || n;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flags = '0; m_res = '0; m_pc = '0;
        m_rv = 0; m_tk = 0; m_redir = 0; m_left = 0;
    endtask

    task automatic model_next();
        logic [2:0] nf, eff;
        bit acc;
        n_flags = m_flags; n_res = m_res; n_pc = m_pc;
        n_rv = m_rv; n_tk = m_tk; n_redir = m_redir; n_left = m_left;
        if (flush) begin
            n_rv = 0; n_tk = 0; n_redir = 0; n_left = 0;
        end else if (!stall) begin
            acc = (m_left == 0);
            nf  = {bus.zr, bus.neg, bus.ov};
            eff = m_flags;
            if (acc && bus.alu_valid)
                for (int i = 0; i < 3; i++) if (bus.flag_we[i]) eff[i] = nf[i];
            n_flags = eff;
            if (acc) n_res = bus.alu_out;
            n_rv = acc && bus.alu_valid;
            n_tk = 0;
            if (m_redir) begin
                n_redir = 0;
                n_left  = SQ;
            end else if (m_left > 0) begin
                n_left = m_left - 1;
            end else if (bus.br_valid && cond_ok(eff, bus.br_cond)) begin
                n_tk    = 1;
                n_pc    = bus.br_target;
                n_redir = 1;
            end
        end
    endtask

    task automatic cyc();
        model_next();
        @(posedge clk);
        m_flags = n_flags; m_res = n_res; m_pc = n_pc;
        m_rv = n_rv; m_tk = n_tk; m_redir = n_redir; m_left = n_left;
        #2;
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_out = '0; bus.zr = 0; bus.neg = 0; bus.ov = 0;
        bus.flag_we = '0; bus.br_valid = 0; bus.br_cond = '0; bus.br_target = '0;
    endtask

    task automatic alu(input logic [DW-1:0] v, input logic [2:0] f, input logic [2:0] we);
        bus.alu_valid = 1; bus.alu_out = v;
        {bus.zr, bus.neg, bus.ov} = f;
        bus.flag_we = we;
    endtask

    task automatic br(input logic [2:0] c, input logic [DW-1:0] t);
        bus.br_valid = 1; bus.br_cond = c; bus.br_target = t;
    endtask

    task automatic idle_cycles(input int n);
        idle();
        for (int i = 0; i < n; i++) cyc();
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("flags_q", 32'(bus.flags_q), 32'(m_flags));
            chk("result_q", 32'(bus.result_q), 32'(m_res));
            chk("result_valid", 32'(bus.result_valid), 32'(m_rv));
            chk("br_taken", 32'(bus.br_taken), 32'(m_tk));
            if (m_tk) chk("br_pc", 32'(bus.br_pc), 32'(m_pc));
            chk("squash", 32'(bus.squash), 32'(m_left > 0));
        end
    end

    initial begin
        idle();
        model_reset();
        #3;
        chk("rst_flags", 32'(bus.flags_q), 0);
        chk("rst_result", 32'(bus.result_q), 0);
        chk("rst_rv", 32'(bus.result_valid), 0);
        chk("rst_taken", 32'(bus.br_taken), 0);
        chk("rst_pc", 32'(bus.br_pc), 0);
        chk("rst_squash", 32'(bus.squash), 0);
        @(negedge clk);
        #1 rst_n = 1;
        chk_en = 1;
        idle_cycles(1);
        chk("idle_taken", 32'(bus.br_taken), 0);

        // Basic write then overflow branch.
        alu(16'h7FFF, 3'b001, 3'b111);
        cyc();
        chk("a_flags", 32'(bus.flags_q), 32'b001);
        chk("a_result", 32'(bus.result_q), 32'h7FFF);
        chk("a_rv", 32'(bus.result_valid), 1);
        idle(); br(3'b110, 16'h0040);
        cyc();
        chk("b_taken", 32'(bus.br_taken), 1);
        chk("b_pc", 32'(bus.br_pc), 32'h0040);
        idle_cycles(1);
        chk("b_taken_drop", 32'(bus.br_taken), 0);
        chk("b_squash1", 32'(bus.squash), 1);
        cyc();
        chk("b_squash2", 32'(bus.squash), 1);
        cyc();
        chk("b_squash_end", 32'(bus.squash), 0);

        // Bypass: Z written and tested in the same cycle.
        alu(16'h0000, 3'b100, 3'b100); br(3'b001, 16'h1234);
        cyc();
        chk("c_taken", 32'(bus.br_taken), 1);
        chk("c_pc", 32'(bus.br_pc), 32'h1234);
        chk("c_flags", 32'(bus.flags_q), 32'b101);
        idle_cycles(3);

        // Partial write.
        alu(16'h8000, 3'b011, 3'b111);
        cyc();
        chk("d_flags011", 32'(bus.flags_q), 32'b011);
        alu(16'h0001, 3'b100, 3'b100);
        cyc();
        chk("d_flags111", 32'(bus.flags_q), 32'b111);
        idle(); br(3'b101, 16'h2000);
        cyc();
        chk("d_lte", 32'(bus.br_taken), 1);
        idle_cycles(3);
        br(3'b010, 16'h3000);
        cyc();
        chk("d_gt", 32'(bus.br_taken), 0);

        // Squash window ignores ALU and branch inputs.
        idle(); br(3'b111, 16'h0100);
        cyc();
        idle_cycles(1);
        alu(16'hAAAA, 3'b000, 3'b111); br(3'b111, 16'hDEAD);
        cyc();
        chk("e_flags_sq1", 32'(bus.flags_q), 32'b111);
        chk("e_rv_sq1", 32'(bus.result_valid), 0);
        chk("e_tk_sq1", 32'(bus.br_taken), 0);
        cyc();
        chk("e_flags_sq2", 32'(bus.flags_q), 32'b111);
        chk("e_rv_sq2", 32'(bus.result_valid), 0);
        bus.br_valid = 0;
        cyc();
        chk("e_flags_acc", 32'(bus.flags_q), 32'b000);
        chk("e_rv_acc", 32'(bus.result_valid), 1);
        chk("e_res_acc", 32'(bus.result_q), 32'hAAAA);

        // Stall holds the squash counter.
        idle(); br(3'b000, 16'h0200);
        cyc();
        idle_cycles(2);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("f_stall_sq", 32'(bus.squash), 1);
        end
        stall = 0;
        cyc();
        chk("f_sq_end", 32'(bus.squash), 0);

        // Flush in REDIRECT.
        alu(16'h8000, 3'b010, 3'b111); br(3'b111, 16'h0300);
        cyc();
        chk("g_taken", 32'(bus.br_taken), 1);
        idle(); flush = 1;
        cyc();
        flush = 0;
        chk("g_fl_taken", 32'(bus.br_taken), 0);
        chk("g_fl_squash", 32'(bus.squash), 0);
        chk("g_fl_flags", 32'(bus.flags_q), 32'b010);
        br(3'b011, 16'h0400);
        cyc();
        chk("g_lt_taken", 32'(bus.br_taken), 1);
        chk("g_lt_pc", 32'(bus.br_pc), 32'h0400);
        idle(); stall = 1;
        cyc();
        chk("g_stall_taken", 32'(bus.br_taken), 1);
        stall = 0;
        idle_cycles(3);

        // Every condition code against every flag value.
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 8; c++) begin
                alu(16'(f * 16 + c), 3'(f), 3'b111); br(3'(c), 16'(c * 256 + f));
                cyc();
                idle_cycles(3);
            end
        end

        // Asynchronous reset mid-operation.
        alu(16'h1111, 3'b111, 3'b111); br(3'b111, 16'h0500);
        cyc();
        #1 rst_n = 0;
        #1;
        model_reset();
        chk("i_rst_flags", 32'(bus.flags_q), 0);
        chk("i_rst_taken", 32'(bus.br_taken), 0);
        chk("i_rst_pc", 32'(bus.br_pc), 0);
        chk("i_rst_rv", 32'(bus.result_valid), 0);
        idle();
        @(negedge clk);
        #1 rst_n = 1;
        idle_cycles(2);
        chk("i_post_taken", 32'(bus.br_taken), 0);
        chk("i_post_flags", 32'(bus.flags_q), 0);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
